// File: rtl/ipsxe_floating_point_result_fifo_v1_0.sv
// Output-side flow control for the fixed-latency FP datapath: issues credits,
// tags in-flight slots, and buffers emerging results in a FWFT FIFO.
module ipsxe_floating_point_result_fifo_v1_0 #(
  parameter int N       = 64,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_aclken,
  input  logic                       i_s_valid,
  output logic                       o_s_ready,
  output logic                       o_issue,
  input  logic [N-1:0]               i_pipe_q,
  output logic                       o_m_valid,
  input  logic                       i_m_ready,
  output logic [N-1:0]               o_m_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  // Handshake: a transfer happens on a cycle where valid & ready & i_aclken
  // are all high; valid never waits on ready, and data is held while stalled.

  logic [LATENCY-1:0] tag;
  logic [IW-1:0]      inflight;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [N-1:0]       mem [DEPTH];
  logic               accept;
  logic               push;
  logic               pop;
  logic               full;
  logic               do_push;
  logic [SW-1:0]      committed;

  // Slots already promised downstream: stored results plus operands still in
  // the pipe, minus the one leaving this cycle.
  assign committed = SW'(o_count) + SW'(inflight) - SW'(pop);
  assign o_s_ready = i_aclken & ~i_rst & (committed < SW'(DEPTH));
  assign accept    = i_s_valid & o_s_ready;
  assign o_issue   = accept;

  assign push      = i_aclken & tag[LATENCY-1];
  assign o_m_valid = (o_count != '0);
  assign pop       = i_aclken & o_m_valid & i_m_ready;
  assign full      = (o_count == CW'(DEPTH));
  assign do_push   = push & (~full | pop);
  assign o_m_data  = o_m_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag        <= '0;
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else if (i_aclken) begin
      tag[0] <= accept;
      for (int k = 1; k < LATENCY; k++) tag[k] <= tag[k-1];

      case ({accept, push})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase

      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)     rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

      case ({do_push, pop})
        2'b10:   o_count <= o_count + CW'(1);
        2'b01:   o_count <= o_count - CW'(1);
        default: o_count <= o_count;
      endcase

      // Only reachable if upstream ignores credits; the result is lost.
      if (push && full && !pop) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_pipe_q;
  end

endmodule

// File: tb/tb_ipsxe_floating_point_result_fifo_v1_0.sv
// Bench for the result FIFO: enabled 4-deep delay line as the datapath,
// queue-based model checked every cycle, plus directed literal checks.
module tb_ipsxe_floating_point_result_fifo_v1_0;

  localparam int N   = 64;
  localparam int LAT = 4;
  localparam int DEP = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          aclken;
  logic          s_valid;
  logic          s_ready;
  logic          issue;
  logic [N-1:0]  s_data;
  logic [N-1:0]  pipe [LAT];
  logic          m_valid;
  logic          m_ready;
  logic [N-1:0]  m_data;
  logic [CW-1:0] count;
  logic          overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ipsxe_floating_point_result_fifo_v1_0 #(.N(N), .LATENCY(LAT), .DEPTH(DEP)) dut (
    .i_clk(clk), .i_rst(rst), .i_aclken(aclken),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .o_issue(issue),
    .i_pipe_q(pipe[LAT-1]),
    .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
    .o_count(count), .o_overflow(overflow)
  );

  // Datapath stand-in: fixed-latency enabled delay line, never stalls.
  always @(posedge clk) begin
    if (aclken) begin
      pipe[0] <= s_data;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: results stored, operands in flight with the enabled-edge number of
  // their acceptance; an operand lands LAT enabled edges after acceptance.
  logic [N-1:0] exp_q[$];
  logic [N-1:0] fl_data[$];
  int           fl_edge[$];
  int           en_edges = 0;
  bit           model_ok = 0;
  bit           m_ovf    = 0;
  bit           m_pop;
  bit           m_ready_e;
  bit           m_full_before;
  logic [N-1:0] m_head;

  always @(negedge clk) begin
    m_pop     = aclken && (exp_q.size() != 0) && m_ready;
    m_ready_e = aclken && !rst && (exp_q.size() + fl_data.size() - int'(m_pop) < DEP);
    m_head    = (exp_q.size() != 0) ? exp_q[0] : '0;
    if (model_ok) begin
      chk("m_s_ready", s_ready, m_ready_e);
      chk("m_issue", issue, s_valid && m_ready_e);
      chk("m_valid", m_valid, exp_q.size() != 0);
      chk("m_data", m_data, m_head);
      chk("m_count", count, exp_q.size());
      chk("m_overflow", overflow, m_ovf);
    end
    if (rst) begin
      exp_q.delete();
      fl_data.delete();
      fl_edge.delete();
      m_ovf    = 0;
      model_ok = 1;
    end else if (aclken) begin
      en_edges++;
      m_full_before = (exp_q.size() == DEP);
      if (m_pop) void'(exp_q.pop_front());
      if (fl_edge.size() != 0 && fl_edge[0] + LAT == en_edges) begin
        if (m_full_before && !m_pop) m_ovf = 1;
        else exp_q.push_back(fl_data[0]);
        void'(fl_data.pop_front());
        void'(fl_edge.pop_front());
      end
      if (s_valid && m_ready_e) begin
        fl_data.push_back(s_data);
        fl_edge.push_back(en_edges);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int nxt;
    int idx;
    logic [CW-1:0] cnt0;
    logic          v0;
    logic [N-1:0]  d0;

    rst = 1'b1; aclken = 1'b1; s_valid = 1'b1; m_ready = 1'b0; s_data = '0;

    // Reset held three cycles with an offered operand.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_issue", issue, 1'b0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_data", m_data, '0);
    end
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 1'b0);

    // Single operand: visible 5 cycles after acceptance, not earlier.
    rst = 1'b0; s_valid = 1'b1; s_data = 64'h3FF0000000000000; m_ready = 1'b1;
    #1;
    chk("single_issue", issue, 1'b1);
    step();
    s_valid = 1'b0;
    repeat (3) step();
    chk("single_c4_valid", m_valid, 1'b0);
    step();
    chk("single_c5_valid", m_valid, 1'b1);
    chk("single_c5_data", m_data, 64'h3FF0000000000000);
    step();
    chk("single_c6_count", count, 0);

    // Backpressure: only DEPTH credits exist.
    m_ready = 1'b0; acc = 0;
    for (int i = 1; i <= 20; i++) begin
      s_valid = 1'b1; s_data = 64'(i);
      #1;
      if (issue) acc++;
      if (i > 8) chk("bp_ready_low", s_ready, 1'b0);
      step();
    end
    chk("bp_accepted", acc, 8);
    chk("bp_count", count, 8);
    chk("bp_overflow", overflow, 1'b0);
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("bp_drain_valid", m_valid, 1'b1);
      chk("bp_drain_data", m_data, 64'(i));
      step();
    end
    chk("bp_empty", count, 0);

    // Streaming at full rate.
    m_ready = 1'b1; nxt = 1;
    for (int c = 0; c < 120; c++) begin
      s_valid = (c < 100); s_data = 64'(c + 1);
      #1;
      if (c < 100) chk("stream_ready", s_ready, 1'b1);
      if (m_valid) begin
        chk("stream_data", m_data, 64'(nxt));
        chk("stream_cycle", 64'(c), 64'(nxt + 4));
        nxt++;
      end
      step();
    end
    chk("stream_total", 64'(nxt), 64'd101);

    // Clock-enable gap mid-stream.
    idx = 1; nxt = 1;
    for (int c = 0; c < 80 && nxt <= 30; c++) begin
      aclken = !(c >= 10 && c <= 12);
      s_valid = (idx <= 30); s_data = 64'(idx + 1000);
      #1;
      if (c == 10) begin
        cnt0 = count; v0 = m_valid; d0 = m_data;
        chk("gate_ready", s_ready, 1'b0);
      end
      if (c == 11 || c == 12) begin
        chk("gate_ready", s_ready, 1'b0);
        chk("gate_count", count, cnt0);
        chk("gate_valid", m_valid, v0);
        chk("gate_data", m_data, d0);
      end
      if (issue) idx++;
      if (m_valid && m_ready && aclken) begin
        chk("gate_order", m_data, 64'(nxt + 1000));
        nxt++;
      end
      step();
    end
    aclken = 1'b1; s_valid = 1'b0;
    chk("gate_total", 64'(nxt), 64'd31);

    // Reset with 2 results stored and 3 operands in flight.
    repeat (3) step();
    m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'b1; s_data = 64'(201 + c);
      step();
    end
    s_valid = 1'b0;
    step();
    chk("mrst_pre_count", count, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_valid", m_valid, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("mrst_no_stale", m_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
